// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencer for the time-multiplexed FIR datapath.
// It accepts one sample per valid/ready handshake, pulses the delay-line
// shift, clears the MAC, and steps tap_sel over every tap. It then holds
// out_valid until the consumer accepts the result.
// Optional feature macro: FIR_CTRL_SAMPLE_CNT_EN adds the 16-bit
// sample_count output, which counts completed results.
// All outputs are decodes of registered state or registers themselves,
// so no input reaches an output combinationally.
module fir_ctrl #(
  parameter int NUM_TAPS = 8,
  parameter int TAP_W    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [TAP_W-1:0] tap_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef FIR_CTRL_SAMPLE_CNT_EN
  ,
  output logic [15:0]      sample_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [TAP_W-1:0] tap_r;

  // State register; reset parks the sequencer in IDLE and abandons any partial result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; handshake inputs are only looked at in the state that owns them
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        next_state_s = MAC;
      end
      MAC: begin
        if (tap_r == LAST_TAP) begin
          next_state_s = DONE;
        end else begin
          next_state_s = MAC;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Tap counter; counts only while in MAC and returns to 0 on the last tap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tap_r <= '0;
    end else if ((state_r == MAC) && (tap_r != LAST_TAP)) begin
      tap_r <= tap_r + TAP_W'(1);
    end else begin
      tap_r <= '0;
    end
  end

  // Output decode of the registered state
  always_comb begin
    in_ready  = 1'b0;
    shift_en  = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      SHIFT: begin
        shift_en = 1'b1;
        mac_clr  = 1'b1;
      end
      MAC: begin
        mac_en = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign tap_sel = tap_r;

`ifdef FIR_CTRL_SAMPLE_CNT_EN
  logic [15:0] sample_count_r;

  // Completed-result counter; bumps on each accepted result and wraps naturally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_count_r <= 16'h0000;
    end else if ((state_r == DONE) && out_ready) begin
      sample_count_r <= sample_count_r + 16'h0001;
    end else begin
      sample_count_r <= sample_count_r;
    end
  end

  assign sample_count = sample_count_r;
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl (NUM_TAPS=8). Inputs are driven and
// outputs are sampled on the falling clock edge.
module tb_fir_ctrl;

  localparam int NUM_TAPS = 8;
  localparam int TAP_W    = 3;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             mac_clr;
  logic             mac_en;
  logic [TAP_W-1:0] tap_sel;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
`ifdef FIR_CTRL_SAMPLE_CNT_EN
  logic [15:0]      sample_count;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  fir_ctrl #(.NUM_TAPS(NUM_TAPS), .TAP_W(TAP_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .tap_sel   (tap_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef FIR_CTRL_SAMPLE_CNT_EN
    ,
    .sample_count (sample_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks every output against the idle/reset values
  task automatic check_idle(input string tag);
    check_value({tag, " in_ready"},  32'(in_ready),  32'd1);
    check_value({tag, " busy"},      32'(busy),      32'd0);
    check_value({tag, " shift_en"},  32'(shift_en),  32'd0);
    check_value({tag, " mac_clr"},   32'(mac_clr),   32'd0);
    check_value({tag, " mac_en"},    32'(mac_en),    32'd0);
    check_value({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check_value({tag, " tap_sel"},   32'(tap_sel),   32'd0);
  endtask

  // Runs one sample through with out_ready=1 from IDLE, ending in IDLE
  task automatic run_sample();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (NUM_TAPS + 2) @(negedge clock);
  endtask

  int shift_seen;
  int ov_seen;
  int last_shift;
  int ov_bad;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    check_idle("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_idle("post_reset");

    // ---- single sample ----
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check_value("single shift_en", 32'(shift_en), 32'd1);
    check_value("single mac_clr",  32'(mac_clr),  32'd1);
    check_value("single shift tap", 32'(tap_sel), 32'd0);
    check_value("single shift in_ready", 32'(in_ready), 32'd0);
    check_value("single shift busy", 32'(busy), 32'd1);
    for (int i = 0; i < NUM_TAPS; i++) begin
      @(negedge clock);
      check_value("single mac_en",   32'(mac_en),   32'd1);
      check_value("single tap_sel",  32'(tap_sel),  32'(i));
      check_value("single mac shift", 32'(shift_en), 32'd0);
      check_value("single mac ov",   32'(out_valid), 32'd0);
    end
    @(negedge clock);
    check_value("single out_valid", 32'(out_valid), 32'd1);
    check_value("single done mac_en", 32'(mac_en), 32'd0);
    check_value("single done tap", 32'(tap_sel), 32'd0);
    @(negedge clock);
    check_idle("single end");

    // ---- back-pressure ----
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    repeat (NUM_TAPS) @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_value("bp out_valid", 32'(out_valid), 32'd1);
      check_value("bp in_ready",  32'(in_ready),  32'd0);
      check_value("bp shift_en",  32'(shift_en),  32'd0);
      check_value("bp tap_sel",   32'(tap_sel),   32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clock);
    check_idle("bp release");

    // ---- continuous stream ----
    shift_seen = 0;
    ov_seen    = 0;
    last_shift = -1;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      @(negedge clock);
      if (c == 110) in_valid = 1'b0;
      if (shift_en) begin
        if (last_shift >= 0) check_value("stream spacing", 32'(c - last_shift), 32'd11);
        last_shift = c;
        shift_seen++;
      end
      if (out_valid) ov_seen++;
    end
    check_value("stream shift count", 32'(shift_seen), 32'd10);
    check_value("stream out_valid count", 32'(ov_seen), 32'd10);
    @(negedge clock);
    check_idle("stream end");

    // ---- async reset mid-MAC ----
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    check_value("arst pre tap", 32'(tap_sel), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    check_idle("arst immediate");
    @(negedge clock);
    reset = 1'b1;
    ov_bad = 0;
    repeat (15) begin
      @(negedge clock);
      if (out_valid) ov_bad++;
    end
    check_value("arst no out_valid", 32'(ov_bad), 32'd0);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check_value("arst restart shift", 32'(shift_en), 32'd1);
    check_value("arst restart tap", 32'(tap_sel), 32'd0);
    repeat (NUM_TAPS + 2) @(negedge clock);
    check_idle("arst restart end");

    // ---- in_valid pulsed only during SHIFT and MAC ----
    in_valid = 1'b1;
    @(negedge clock);
    shift_seen = 0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      in_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clock);
      if (shift_en) shift_seen++;
    end
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (shift_en) shift_seen++;
    end
    check_value("ignore no extra shift", 32'(shift_seen), 32'd0);
    check_idle("ignore end");
    repeat (3) @(negedge clock);
    check_idle("ignore stays idle");

`ifdef FIR_CTRL_SAMPLE_CNT_EN
    // ---- sample counter wrap ----
    force dut.sample_count_r = 16'hFFFE;
    @(negedge clock);
    release dut.sample_count_r;
    run_sample();
    check_value("cnt ffff", 32'(sample_count), 32'h0000FFFF);
    run_sample();
    check_value("cnt 0000", 32'(sample_count), 32'h00000000);
    run_sample();
    check_value("cnt 0001", 32'(sample_count), 32'h00000001);
`else
    run_sample();
    check_idle("extra sample end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Sequencer for the time-multiplexed FIR datapath. Accepts one input sample per valid/ready handshake, then pulses the shift enable of the 16-bit tap delay line (dff_16bit chain). It next clears the MAC and steps the coefficient/tap select over all taps, and finally holds the result valid until the downstream consumer accepts it. It sits between the sample source and the FIR datapath and is the only driver of the delay-line and MAC control signals.

## Interface
- NUM_TAPS, 8, number of filter taps; legal range 2..256
- TAP_W, 3, width of tap_sel; must equal clog2(NUM_TAPS)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream sample valid
- in_ready  output  1  controller can accept a sample
- shift_en  output  1  one-cycle enable to the delay-line registers (load new sample, shift taps)
- mac_clr  output  1  one-cycle accumulator clear
- mac_en  output  1  accumulate product of tap[tap_sel] × coef[tap_sel]
- tap_sel  output  TAP_W  tap/coefficient index
- out_valid  output  1  accumulator holds a finished result
- out_ready  input  1  downstream accepts the result
- busy  output  1  high in every state except IDLE
- sample_count  output  16  completed outputs; present only with FIR_CTRL_SAMPLE_CNT_EN

## Operation
- States: IDLE, SHIFT, MAC, DONE. All outputs are registered or pure state decodes; no input-to-output combinational path.
- IDLE: in_ready=1. On in_valid=1 at a clock edge, go to SHIFT. Otherwise stay.
- SHIFT, one cycle: shift_en=1, mac_clr=1, tap_sel=0. Always go to MAC.
- MAC, NUM_TAPS cycles: mac_en=1 and tap_sel=0,1,…,NUM_TAPS-1 in consecutive cycles.
  - When tap_sel=NUM_TAPS-1, go to DONE and reset tap_sel to 0 on the same edge.
- DONE: out_valid=1. Stay until out_ready=1 at an edge, then go to IDLE.
- in_valid is ignored outside IDLE. in_ready=0 in SHIFT, MAC and DONE, so the datapath never sees a shift mid-accumulation.
- out_ready is ignored outside DONE.
- shift_en, mac_clr and mac_en are never high in DONE or IDLE.
- tap_sel is 0 in all states except MAC.
- Reset (reset=0), asynchronous, any state:
  - State goes to IDLE and tap_sel to 0.
  - shift_en, mac_clr, mac_en, out_valid and busy go to 0; in_ready goes to 1.
  - sample_count goes to 0.
  - A mid-MAC reset abandons the partial result; no out_valid follows.

## Timing
- Sample accepted at edge k. shift_en and mac_clr are high in cycle k..k+1. mac_en is high for cycles k+1..k+1+NUM_TAPS. out_valid rises at edge k+1+NUM_TAPS.
- Latency from accept to out_valid is NUM_TAPS+1 edges (9 for NUM_TAPS=8).
- Minimum period per sample is NUM_TAPS+3 cycles: SHIFT + NUM_TAPS MAC cycles + DONE (with out_ready=1) + IDLE.
- out_valid, once high, stays high with constant tap_sel=0 until the accepting edge, then falls on that edge.
- The tap counter wraps only via the MAC-to-DONE transition. It never counts past NUM_TAPS-1.

## Configuration
- FIR_CTRL_SAMPLE_CNT_EN defined:
  - Adds the sample_count output port.
  - The counter increments by 1 on each DONE-to-IDLE transition (out_valid & out_ready) and wraps from 16'hFFFF to 16'h0000.
  - Reset value is 0.
- FIR_CTRL_SAMPLE_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then single sample (NUM_TAPS=8): in_valid=1 for one edge with out_ready=1.
  - shift_en pulses once, then mac_en is high 8 cycles with tap_sel 0..7.
  - out_valid is high 9 edges after accept for exactly 1 cycle; busy then falls.
- Back-pressure: out_ready=0 for 20 cycles after out_valid rises.
  - out_valid holds, in_ready stays 0, and a held in_valid=1 produces no shift_en.
  - Raising out_ready gives IDLE on the next edge.
- Continuous stream: in_valid and out_ready tied 1 for 10 samples.
  - 10 shift_en pulses spaced exactly 11 cycles apart and 10 out_valid pulses.
- Async reset mid-MAC: assert reset at tap_sel=4 between clock edges.
  - All outputs go to their reset values immediately, without a clock edge, and no out_valid follows.
  - The next in_valid restarts from SHIFT.
- in_valid pulsed during SHIFT and MAC only, never in IDLE: no second shift_en occurs and the state machine returns to IDLE.
- With FIR_CTRL_SAMPLE_CNT_EN: force the counter to 16'hFFFE and complete 3 samples; sample_count reads FFFF, 0000, 0001.
